// File: rtl/i2c_pkg.sv
// Shared types for the I2C master scheduler slice.
//   cmd_e         : command codes understood by i2c_byte_engine
//   sched_state_e : transaction sequencer states
//   I2C_ADDR_W    : 7-bit target address width
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_STOP  = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_RESP  = 3'd5
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : index given first priority (must be < N_REQ)
//   grant     : one-hot grant of the first requester at or after ptr
//   any_grant : at least one request present
module rr_arbiter #(
  parameter  int unsigned N_REQ = 2,
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic             any_grant
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_grant = |req;

endmodule

// File: rtl/i2c_master_sched.sv
// Shares one I2C byte engine between N_REQ requesters.
// Round-robin grant, latch the transaction, then sequence the engine through
// START, address WRITE, DATA bytes (WRITE or READ), STOP, and report back.
//   req_*       : per-requester transaction request / accept pulse
//   rsp_*       : completion pulse to owner plus status/data (held until next grant)
//   bus_busy    : another master owns the bus; blocks new grants
//   eng_cmd_*   : command handshake to the byte engine
//   eng_rsp_*   : engine completion with NACK flag / read byte
//   sched_busy  : high whenever a transaction is in flight
module i2c_master_sched
  import i2c_pkg::*;
#(
  parameter  int unsigned N_REQ   = 2,
  parameter  int unsigned MAX_LEN = 4,
  localparam int unsigned LEN_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic                          clk100,
  input  logic                          reset_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*I2C_ADDR_W-1:0]   req_addr,
  input  logic [N_REQ-1:0]              req_rw,
  input  logic [N_REQ*LEN_W-1:0]        req_len,
  input  logic [N_REQ*8*MAX_LEN-1:0]    req_wdata,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic                          rsp_nack,
  output logic [LEN_W:0]                rsp_nbytes,
  output logic [8*MAX_LEN-1:0]          rsp_rdata,
  input  logic                          bus_busy,
  output logic                          eng_cmd_valid,
  input  logic                          eng_cmd_ready,
  output logic [1:0]                    eng_cmd,
  output logic [7:0]                    eng_wdata,
  output logic                          eng_ack_out,
  input  logic                          eng_rsp_valid,
  input  logic                          eng_rsp_nack,
  input  logic [7:0]                    eng_rsp_rdata,
  output logic                          sched_busy
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_e          state_q, state_d;
  logic                  sent_q, sent_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [I2C_ADDR_W-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [8*MAX_LEN-1:0]  wdata_q, wdata_d;
  logic [8*MAX_LEN-1:0]  rdata_q, rdata_d;
  logic                  nack_q, nack_d;
  logic [LEN_W:0]        nbytes_q, nbytes_d;
  logic [N_REQ-1:0]      req_ready_q, req_ready_d;

  logic [N_REQ-1:0]      grant;
  logic                  any_grant;
  logic [PTR_W-1:0]      grant_idx;
  logic                  cmd_state;
  logic                  cmd_done;
  cmd_e                  cmd;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .any_grant (any_grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_idx = PTR_W'(i);
    end
  end

  // sent_q splits each command state into "offering command" and
  // "waiting for engine response"; responses are only honoured in the latter.
  assign cmd_state     = (state_q == ST_START) || (state_q == ST_ADDR) ||
                         (state_q == ST_DATA)  || (state_q == ST_STOP);
  assign eng_cmd_valid = cmd_state && !sent_q;
  assign cmd_done      = cmd_state && sent_q && eng_rsp_valid;

  always_comb begin
    cmd         = CMD_START;
    eng_wdata   = '0;
    eng_ack_out = 1'b0;
    if (eng_cmd_valid) begin
      case (state_q)
        ST_START: cmd = CMD_START;
        ST_ADDR: begin
          cmd       = CMD_WRITE;
          eng_wdata = {addr_q, rw_q};
        end
        ST_DATA: begin
          if (rw_q) begin
            cmd         = CMD_READ;
            eng_ack_out = (cnt_q != len_q);
          end else begin
            cmd       = CMD_WRITE;
            eng_wdata = wdata_q[cnt_q*8 +: 8];
          end
        end
        ST_STOP: cmd = CMD_STOP;
        default: cmd = CMD_START;
      endcase
    end
  end

  assign eng_cmd    = cmd;
  assign req_ready  = req_ready_q;
  assign rsp_valid  = (state_q == ST_RESP) ? (N_REQ'(1) << owner_q) : '0;
  assign rsp_nack   = nack_q;
  assign rsp_nbytes = nbytes_q;
  assign rsp_rdata  = rdata_q;
  assign sched_busy = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    sent_d      = sent_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    nack_d      = nack_q;
    nbytes_d    = nbytes_q;
    req_ready_d = '0;

    if (eng_cmd_valid && eng_cmd_ready) sent_d = 1'b1;
    if (cmd_done)                       sent_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_grant && !bus_busy) begin
          owner_d     = grant_idx;
          ptr_d       = (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
          addr_d      = req_addr[grant_idx*I2C_ADDR_W +: I2C_ADDR_W];
          rw_d        = req_rw[grant_idx];
          len_d       = req_len[grant_idx*LEN_W +: LEN_W];
          wdata_d     = req_wdata[grant_idx*8*MAX_LEN +: 8*MAX_LEN];
          nack_d      = 1'b0;
          nbytes_d    = '0;
          rdata_d     = '0;
          cnt_d       = '0;
          sent_d      = 1'b0;
          req_ready_d = grant;
          state_d     = ST_START;
        end
      end
      ST_START: if (cmd_done) state_d = ST_ADDR;
      ST_ADDR: begin
        if (cmd_done) begin
          if (eng_rsp_nack) begin
            nack_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            cnt_d   = '0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (cmd_done) begin
          if (!rw_q && eng_rsp_nack) begin
            nack_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            nbytes_d = nbytes_q + 1'b1;
            if (rw_q) rdata_d[cnt_q*8 +: 8] = eng_rsp_rdata;
            if (cnt_q == len_q) state_d = ST_STOP;
            else                cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      ST_STOP: if (cmd_done) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sent_q      <= 1'b0;
      ptr_q       <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      nack_q      <= 1'b0;
      nbytes_q    <= '0;
      req_ready_q <= '0;
    end else begin
      state_q     <= state_d;
      sent_q      <= sent_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      nack_q      <= nack_d;
      nbytes_q    <= nbytes_d;
      req_ready_q <= req_ready_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_sched.sv
// Scoreboard bench for i2c_master_sched with a behavioural byte-engine model.
module tb_i2c_master_sched;
  import i2c_pkg::*;

  logic        clk100 = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, req_rw, rsp_valid;
  logic [13:0] req_addr;
  logic [3:0]  req_len;
  logic [63:0] req_wdata;
  logic        rsp_nack;
  logic [2:0]  rsp_nbytes;
  logic [31:0] rsp_rdata;
  logic        bus_busy;
  logic        eng_cmd_valid, eng_cmd_ready;
  logic [1:0]  eng_cmd;
  logic [7:0]  eng_wdata;
  logic        eng_ack_out;
  logic        eng_rsp_valid, eng_rsp_nack;
  logic [7:0]  eng_rsp_rdata;
  logic        sched_busy;

  always #5 clk100 = ~clk100;

  i2c_master_sched #(.N_REQ(2), .MAX_LEN(4)) dut (
    .clk100(clk100), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rw(req_rw), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_nbytes(rsp_nbytes),
    .rsp_rdata(rsp_rdata), .bus_busy(bus_busy),
    .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
    .eng_cmd(eng_cmd), .eng_wdata(eng_wdata), .eng_ack_out(eng_ack_out),
    .eng_rsp_valid(eng_rsp_valid), .eng_rsp_nack(eng_rsp_nack),
    .eng_rsp_rdata(eng_rsp_rdata), .sched_busy(sched_busy)
  );

  typedef struct {
    logic [1:0]  owner;
    logic        nack;
    logic [2:0]  nbytes;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] val;
  } cmd_t;

  rsp_t       exp_rsp_q[$];
  cmd_t       exp_cmd_q[$];
  logic [1:0] exp_grant_q[$];
  logic [7:0] rd_q[$];

  int total = 0;
  int bad   = 0;
  int nack_at  = -1;
  int stall_at = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Engine model: accepts a command, answers one cycle later.
  initial begin : engine
    int         wr_idx;
    bit         pend;
    logic       pend_nack;
    logic [7:0] pend_rdata;
    logic [7:0] act_val;
    cmd_t       e;
    wr_idx = 0; pend = 0; pend_nack = 0; pend_rdata = 0;
    eng_cmd_ready = 0; eng_rsp_valid = 0; eng_rsp_nack = 0; eng_rsp_rdata = 0;
    forever begin
      @(posedge clk100); #1;
      eng_cmd_ready = 0; eng_rsp_valid = 0; eng_rsp_nack = 0; eng_rsp_rdata = 0;
      if (!reset_n) begin
        wr_idx = 0;
        pend   = 0;
      end else if (pend) begin
        eng_rsp_valid = 1; eng_rsp_nack = pend_nack; eng_rsp_rdata = pend_rdata;
        pend = 0;
      end else if (eng_cmd_valid && !(eng_cmd == CMD_WRITE && wr_idx == stall_at)) begin
        eng_cmd_ready = 1;
        pend = 1; pend_nack = 0; pend_rdata = 0;
        act_val = (eng_cmd == CMD_WRITE) ? eng_wdata :
                  (eng_cmd == CMD_READ)  ? {7'b0, eng_ack_out} : 8'h00;
        if (exp_cmd_q.size() == 0) fail("cmd_unexpected");
        else begin
          e = exp_cmd_q.pop_front();
          check("cmd_kind", 32'(eng_cmd), 32'(e.cmd));
          check("cmd_val", 32'(act_val), 32'(e.val));
        end
        case (eng_cmd)
          CMD_START: wr_idx = 0;
          CMD_WRITE: begin
            pend_nack = (wr_idx == nack_at);
            wr_idx++;
          end
          CMD_READ: pend_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
          default: ;
        endcase
      end
    end
  end

  // Monitor: grants and completions against the scoreboard queues.
  initial begin : monitor
    rsp_t       r;
    logic [1:0] g;
    forever begin
      @(negedge clk100);
      if (reset_n) begin
        if (req_ready != 2'b00) begin
          check("ready_onehot", 32'($countones(req_ready)), 32'd1);
          if (exp_grant_q.size() == 0) fail("grant_unexpected");
          else begin
            g = exp_grant_q.pop_front();
            check("grant", 32'(req_ready), 32'(g));
          end
        end
        if (rsp_valid != 2'b00) begin
          if (exp_rsp_q.size() == 0) fail("rsp_unexpected");
          else begin
            r = exp_rsp_q.pop_front();
            check("rsp_owner", 32'(rsp_valid), 32'(r.owner));
            check("rsp_nack", 32'(rsp_nack), 32'(r.nack));
            check("rsp_nbytes", 32'(rsp_nbytes), 32'(r.nbytes));
            check("rsp_rdata", rsp_rdata, r.rdata);
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [6:0] a, input logic rw,
                         input logic [1:0] len, input logic [31:0] wd);
    req_addr[i*7 +: 7]    = a;
    req_rw[i]             = rw;
    req_len[i*2 +: 2]     = len;
    req_wdata[i*32 +: 32] = wd;
  endtask

  task automatic push_cmd(input logic [1:0] c, input logic [7:0] v);
    cmd_t e;
    e.cmd = c;
    e.val = v;
    exp_cmd_q.push_back(e);
  endtask

  task automatic push_rsp(input logic [1:0] o, input logic n, input logic [2:0] nb,
                          input logic [31:0] rd);
    rsp_t r;
    r.owner = o; r.nack = n; r.nbytes = nb; r.rdata = rd;
    exp_rsp_q.push_back(r);
  endtask

  task automatic serve(input int n0, input int n1);
    int s0 = 0;
    int s1 = 0;
    int cyc = 0;
    while ((s0 < n0 || s1 < n1) && cyc < 2000) begin
      @(negedge clk100);
      cyc++;
      if (req_ready[0]) begin s0++; if (s0 >= n0) req_valid[0] = 1'b0; end
      if (req_ready[1]) begin s1++; if (s1 >= n1) req_valid[1] = 1'b0; end
    end
    if (cyc >= 2000) begin
      fail("serve_timeout");
      req_valid = 2'b00;
    end
  endtask

  task automatic drain();
    int cyc = 0;
    while ((exp_rsp_q.size() != 0 || exp_cmd_q.size() != 0 ||
            exp_grant_q.size() != 0 || sched_busy) && cyc < 1000) begin
      @(negedge clk100);
      cyc++;
    end
    if (cyc >= 1000) begin
      fail("drain_timeout");
      exp_rsp_q.delete(); exp_cmd_q.delete(); exp_grant_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_nack"}, 32'(rsp_nack), 32'd0);
    check({tag, "_rsp_nbytes"}, 32'(rsp_nbytes), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_eng_valid"}, 32'(eng_cmd_valid), 32'd0);
    check({tag, "_eng_fields"}, {21'd0, eng_cmd, eng_wdata, eng_ack_out}, 32'd0);
    check({tag, "_busy"}, 32'(sched_busy), 32'd0);
  endtask

  initial begin : stim
    int cyc;
    reset_n = 0; req_valid = 0; req_addr = 0; req_rw = 0; req_len = 0;
    req_wdata = 0; bus_busy = 0;
    repeat (3) @(negedge clk100);
    check_all_zero("reset");
    reset_n = 1;
    @(negedge clk100);

    // 1: write 2 bytes, plus grant/START latency
    set_req(0, 7'h42, 1'b0, 2'd1, 32'h0000BEEF);
    push_cmd(CMD_START, 8'h00); push_cmd(CMD_WRITE, 8'h84);
    push_cmd(CMD_WRITE, 8'hEF); push_cmd(CMD_WRITE, 8'hBE); push_cmd(CMD_STOP, 8'h00);
    exp_grant_q.push_back(2'b01);
    push_rsp(2'b01, 1'b0, 3'd2, 32'h0);
    req_valid[0] = 1'b1;
    @(negedge clk100);
    check("lat_ready", 32'(req_ready), 32'b01);
    check("lat_start", {30'd0, eng_cmd_valid, eng_cmd == CMD_START}, 32'b11);
    req_valid[0] = 1'b0;
    drain();

    // 2: read 3 bytes
    set_req(1, 7'h42, 1'b1, 2'd2, 32'h0);
    rd_q.push_back(8'h11); rd_q.push_back(8'h22); rd_q.push_back(8'h33);
    push_cmd(CMD_START, 8'h00); push_cmd(CMD_WRITE, 8'h85);
    push_cmd(CMD_READ, 8'h01); push_cmd(CMD_READ, 8'h01); push_cmd(CMD_READ, 8'h00);
    push_cmd(CMD_STOP, 8'h00);
    exp_grant_q.push_back(2'b10);
    push_rsp(2'b10, 1'b0, 3'd3, 32'h00332211);
    req_valid[1] = 1'b1;
    serve(0, 1); drain();

    // 3: address NACK (also shows rdata cleared on new grant)
    nack_at = 0;
    set_req(0, 7'h10, 1'b0, 2'd3, 32'hDEADBEEF);
    push_cmd(CMD_START, 8'h00); push_cmd(CMD_WRITE, 8'h20); push_cmd(CMD_STOP, 8'h00);
    exp_grant_q.push_back(2'b01);
    push_rsp(2'b01, 1'b1, 3'd0, 32'h0);
    req_valid[0] = 1'b1;
    serve(1, 0); drain();

    // 3b: NACK on second data byte
    nack_at = 2;
    set_req(1, 7'h7F, 1'b0, 2'd3, 32'h44332211);
    push_cmd(CMD_START, 8'h00); push_cmd(CMD_WRITE, 8'hFE);
    push_cmd(CMD_WRITE, 8'h11); push_cmd(CMD_WRITE, 8'h22); push_cmd(CMD_STOP, 8'h00);
    exp_grant_q.push_back(2'b10);
    push_rsp(2'b10, 1'b1, 3'd1, 32'h0);
    req_valid[1] = 1'b1;
    serve(0, 1); drain();
    nack_at = -1;

    // 3c: max length write
    set_req(0, 7'h01, 1'b0, 2'd3, 32'h44332211);
    push_cmd(CMD_START, 8'h00); push_cmd(CMD_WRITE, 8'h02);
    push_cmd(CMD_WRITE, 8'h11); push_cmd(CMD_WRITE, 8'h22);
    push_cmd(CMD_WRITE, 8'h33); push_cmd(CMD_WRITE, 8'h44); push_cmd(CMD_STOP, 8'h00);
    exp_grant_q.push_back(2'b01);
    push_rsp(2'b01, 1'b0, 3'd4, 32'h0);
    req_valid[0] = 1'b1;
    serve(1, 0); drain();

    // 3d: single-byte read, master NACKs it
    set_req(1, 7'h50, 1'b1, 2'd0, 32'h0);
    rd_q.push_back(8'hA5);
    push_cmd(CMD_START, 8'h00); push_cmd(CMD_WRITE, 8'hA1);
    push_cmd(CMD_READ, 8'h00); push_cmd(CMD_STOP, 8'h00);
    exp_grant_q.push_back(2'b10);
    push_rsp(2'b10, 1'b0, 3'd1, 32'h000000A5);
    req_valid[1] = 1'b1;
    serve(0, 1); drain();

    // 4: both held across four transactions, pointer at 0
    set_req(0, 7'h33, 1'b0, 2'd0, 32'h0000005A);
    set_req(1, 7'h33, 1'b1, 2'd0, 32'h0);
    rd_q.push_back(8'h77); rd_q.push_back(8'h78);
    for (int k = 0; k < 2; k++) begin
      push_cmd(CMD_START, 8'h00); push_cmd(CMD_WRITE, 8'h66);
      push_cmd(CMD_WRITE, 8'h5A); push_cmd(CMD_STOP, 8'h00);
      push_cmd(CMD_START, 8'h00); push_cmd(CMD_WRITE, 8'h67);
      push_cmd(CMD_READ, 8'h00); push_cmd(CMD_STOP, 8'h00);
      exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b10);
      push_rsp(2'b01, 1'b0, 3'd1, 32'h0);
      push_rsp(2'b10, 1'b0, 3'd1, (k == 0) ? 32'h77 : 32'h78);
    end
    req_valid = 2'b11;
    serve(2, 2); drain();

    // 5: bus_busy blocks grants
    bus_busy = 1'b1;
    set_req(0, 7'h08, 1'b0, 2'd0, 32'h00000001);
    req_valid[0] = 1'b1;
    repeat (4) begin
      @(negedge clk100);
      check("busy_hold", {30'd0, req_ready[0], eng_cmd_valid}, 32'd0);
    end
    push_cmd(CMD_START, 8'h00); push_cmd(CMD_WRITE, 8'h10);
    push_cmd(CMD_WRITE, 8'h01); push_cmd(CMD_STOP, 8'h00);
    exp_grant_q.push_back(2'b01);
    push_rsp(2'b01, 1'b0, 3'd1, 32'h0);
    bus_busy = 1'b0;
    @(negedge clk100);
    check("busy_release", 32'(req_ready), 32'b01);
    req_valid[0] = 1'b0;
    drain();

    // 6: reset during stalled DATA
    stall_at = 1;
    set_req(0, 7'h22, 1'b0, 2'd3, 32'h44332211);
    push_cmd(CMD_START, 8'h00); push_cmd(CMD_WRITE, 8'h44);
    exp_grant_q.push_back(2'b01);
    req_valid[0] = 1'b1;
    serve(1, 0);
    cyc = 0;
    while (!(eng_cmd_valid && eng_cmd == CMD_WRITE && eng_wdata == 8'h11) && cyc < 200) begin
      @(negedge clk100);
      cyc++;
    end
    if (cyc >= 200) fail("stall_timeout");
    repeat (2) @(negedge clk100);
    check("stall_held", {23'd0, eng_cmd_valid, eng_wdata}, {23'd0, 1'b1, 8'h11});
    reset_n = 1'b0;
    @(negedge clk100);
    check_all_zero("midreset");
    check("midreset_cmds", 32'(exp_cmd_q.size()), 32'd0);
    reset_n = 1'b1;
    stall_at = -1;
    exp_cmd_q.delete();
    exp_grant_q.delete();

    // after reset the pointer is 0: requester 0 wins first
    set_req(0, 7'h11, 1'b0, 2'd0, 32'h0000000F);
    set_req(1, 7'h12, 1'b0, 2'd0, 32'h000000F0);
    push_cmd(CMD_START, 8'h00); push_cmd(CMD_WRITE, 8'h22);
    push_cmd(CMD_WRITE, 8'h0F); push_cmd(CMD_STOP, 8'h00);
    push_cmd(CMD_START, 8'h00); push_cmd(CMD_WRITE, 8'h24);
    push_cmd(CMD_WRITE, 8'hF0); push_cmd(CMD_STOP, 8'h00);
    exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b10);
    push_rsp(2'b01, 1'b0, 3'd1, 32'h0);
    push_rsp(2'b10, 1'b0, 3'd1, 32'h0);
    req_valid = 2'b11;
    serve(1, 1); drain();

    repeat (3) @(negedge clk100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
